fifo_ptr_ctrl: RTL and testbench

Parametrised read/write pointer controller for FIFO_Mem. It is the successor to the single-side pointer updater: one block owns both pointers, generates its own full/empty flags from wrap-bit comparison, and supports any depth, not only powers of two. It also provides fill count, programmable almost-full/almost-empty, flush, optional full-passthrough, and sticky overflow/underflow errors. It sits between the FIFO's push/pop interface and the storage array, driving the array's write/read enables and addresses.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_ptr_cnt.sv | 22 ++
 rtl/fifo_ptr_ctrl.sv | 69 ++++++
 tb/tb_fifo_ptr_ctrl.sv | 113 +++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: wrapping pointer type, pointer increment and threshold legality check
package fifo_pkg;
  localparam int ADDR_W = 32;
  typedef struct packed {
    logic              wrap;
    logic [ADDR_W-1:0] addr;
  } ptr_t;
  function automatic ptr_t ptr_inc(input ptr_t p, input int depth);
    ptr_t r;
    logic last;
    last = p.addr == ADDR_W'(depth - 1);
    r.wrap = p.wrap ^ last;
    r.addr = last ? '0 : p.addr + ADDR_W'(1);
    return r;
  endfunction
  function automatic bit thresh_ok(input int ae, input int af, input int depth);
    return depth >= 2 && ae >= 0 && ae < af && af <= depth;
  endfunction
endpackage

// File: rtl/fifo_ptr_cnt.sv
// fifo_ptr_cnt: one wrapping pointer with wrap bit (clk_in, areset_b, clr, en -> ptr address, nxt next-state)
module fifo_ptr_cnt
  import fifo_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int PTR_SIZE = $clog2(DEPTH)
) (
  input  logic                clk_in,
  input  logic                areset_b,
  input  logic                clr,
  input  logic                en,
  output logic [PTR_SIZE-1:0] ptr,
  output ptr_t                nxt
);
  ptr_t q;
  always_comb nxt = clr ? '0 : en ? ptr_inc(q, DEPTH) : q;
  always_ff @(posedge clk_in) begin
    if (!areset_b) q <= '0;
    else q <= nxt;
  end
  assign ptr = q.addr[PTR_SIZE-1:0];
endmodule

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: FIFO read/write pointer controller (push/pop/flush/err_clr in; enables, pointers, fill count, status and sticky errors out)
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int PTR_SIZE      = $clog2(DEPTH),
  parameter int AF_THRESH     = DEPTH - 1,
  parameter int AE_THRESH     = 1,
  parameter bit FULL_PASSTHRU = 1'b0
) (
  input  logic                clk_in,
  input  logic                areset_b,
  input  logic                wr_req,
  input  logic                rd_req,
  input  logic                flush,
  input  logic                err_clr,
  output logic                wr_en,
  output logic                rd_en,
  output logic [PTR_SIZE-1:0] wr_ptr,
  output logic [PTR_SIZE-1:0] rd_ptr,
  output logic [PTR_SIZE:0]   fill_cnt,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                overflow,
  output logic                underflow
);
  localparam logic [PTR_SIZE:0] AF_W = (PTR_SIZE + 1)'(AF_THRESH);
  localparam logic [PTR_SIZE:0] AE_W = (PTR_SIZE + 1)'(AE_THRESH);
  if (!thresh_ok(AE_THRESH, AF_THRESH, DEPTH)) begin : g_bad_cfg
    $error("fifo_ptr_ctrl: need DEPTH>=2 and 0 <= AE_THRESH < AF_THRESH <= DEPTH");
  end
  ptr_t              wp_n, rp_n;
  logic [PTR_SIZE:0] cnt_n;
  logic              ovf_n, unf_n;
  assign rd_en = rd_req & ~empty & ~flush;
  assign wr_en = wr_req & ~flush & (~full | (FULL_PASSTHRU & rd_en));
  fifo_ptr_cnt #(.DEPTH(DEPTH), .PTR_SIZE(PTR_SIZE)) u_wr (
    .clk_in(clk_in), .areset_b(areset_b), .clr(flush), .en(wr_en), .ptr(wr_ptr), .nxt(wp_n)
  );
  fifo_ptr_cnt #(.DEPTH(DEPTH), .PTR_SIZE(PTR_SIZE)) u_rd (
    .clk_in(clk_in), .areset_b(areset_b), .clr(flush), .en(rd_en), .ptr(rd_ptr), .nxt(rp_n)
  );
  always_comb begin
    cnt_n = flush ? '0 : (wr_en & ~rd_en) ? fill_cnt + 1'b1 : (rd_en & ~wr_en) ? fill_cnt - 1'b1 : fill_cnt;
    ovf_n = (wr_req & ~wr_en & ~flush) | (overflow & ~err_clr);
    unf_n = (rd_req & ~rd_en & ~flush) | (underflow & ~err_clr);
  end
  always_ff @(posedge clk_in) begin
    if (!areset_b) begin
      fill_cnt     <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      fill_cnt     <= cnt_n;
      full         <= (wp_n.addr == rp_n.addr) && (wp_n.wrap != rp_n.wrap);
      empty        <= wp_n == rp_n;
      almost_full  <= cnt_n >= AF_W;
      almost_empty <= cnt_n <= AE_W;
      overflow     <= ovf_n;
      underflow    <= unf_n;
    end
  end
endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// tb_fifo_ptr_ctrl: scoreboard bench for fifo_ptr_ctrl at DEPTH=6, with and without full passthrough
module tb_fifo_ptr_ctrl;
  logic clk_in = 1'b0;
  logic areset_b, wr_req, rd_req, flush, err_clr;
  logic       wen[2], ren[2], f_o[2], e_o[2], af_o[2], ae_o[2], o_o[2], u_o[2];
  logic [2:0] wp_o[2], rp_o[2];
  logic [3:0] cnt_o[2];
  logic       cwen[2], cren[2];
  int n_vec = 0, n_bad = 0;
  typedef struct {
    int sel;
    bit cc, wen, ren;
    int wp, rp, cnt;
    bit f, e, af, ae, o, u;
  } exp_t;
  exp_t q[$];
  always #5 clk_in = ~clk_in;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    fifo_ptr_ctrl #(.DEPTH(6), .AF_THRESH(5), .AE_THRESH(1), .FULL_PASSTHRU(g == 1)) u_dut (
      .clk_in(clk_in), .areset_b(areset_b), .wr_req(wr_req), .rd_req(rd_req), .flush(flush),
      .err_clr(err_clr), .wr_en(wen[g]), .rd_en(ren[g]), .wr_ptr(wp_o[g]), .rd_ptr(rp_o[g]),
      .fill_cnt(cnt_o[g]), .full(f_o[g]), .empty(e_o[g]), .almost_full(af_o[g]),
      .almost_empty(ae_o[g]), .overflow(o_o[g]), .underflow(u_o[g])
    );
  end
  task automatic cmp(input string nm, input int sel, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: got %0d, expected %0d", nm, sel, $time, act, exp);
    end
  endtask
  initial forever begin
    exp_t x;
    @(negedge clk_in);
    #2;
    for (int i = 0; i < 2; i++) begin
      cwen[i] = wen[i];
      cren[i] = ren[i];
    end
    @(posedge clk_in);
    #1;
    while (q.size() > 0) begin
      x = q.pop_front();
      if (x.cc) begin
        cmp("wr_en", x.sel, int'(cwen[x.sel]), int'(x.wen));
        cmp("rd_en", x.sel, int'(cren[x.sel]), int'(x.ren));
      end
      cmp("wr_ptr", x.sel, int'(wp_o[x.sel]), x.wp);
      cmp("rd_ptr", x.sel, int'(rp_o[x.sel]), x.rp);
      cmp("fill_cnt", x.sel, int'(cnt_o[x.sel]), x.cnt);
      cmp("full", x.sel, int'(f_o[x.sel]), int'(x.f));
      cmp("empty", x.sel, int'(e_o[x.sel]), int'(x.e));
      cmp("almost_full", x.sel, int'(af_o[x.sel]), int'(x.af));
      cmp("almost_empty", x.sel, int'(ae_o[x.sel]), int'(x.ae));
      cmp("overflow", x.sel, int'(o_o[x.sel]), int'(x.o));
      cmp("underflow", x.sel, int'(u_o[x.sel]), int'(x.u));
    end
  end
  task automatic push(input bit [1:0] mask, input bit cc, input bit we, input bit re, input int wp,
                      input int rp, input int cnt, input bit f, input bit e, input bit af,
                      input bit ae, input bit o, input bit u);
    for (int i = 0; i < 2; i++)
      if (mask[i]) q.push_back('{i, cc, we, re, wp, rp, cnt, f, e, af, ae, o, u});
  endtask
  task automatic drive(input bit w, input bit r, input bit fl, input bit ec);
    @(negedge clk_in);
    areset_b = 1'b1;
    wr_req   = w;
    rd_req   = r;
    flush    = fl;
    err_clr  = ec;
  endtask
  task automatic step(input bit w, input bit r, input bit fl, input bit ec, input bit we,
                      input bit re, input int wp, input int rp, input int cnt, input bit f,
                      input bit e, input bit af, input bit ae, input bit o, input bit u);
    drive(w, r, fl, ec);
    push(2'b11, 1'b1, we, re, wp, rp, cnt, f, e, af, ae, o, u);
  endtask
  initial begin
    areset_b = 1'b0;
    wr_req   = 1'b0;
    rd_req   = 1'b0;
    flush    = 1'b0;
    err_clr  = 1'b0;
    @(negedge clk_in);
    push(2'b11, 1'b0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    for (int k = 1; k <= 6; k++)
      step(1, 0, 0, 0, 1, 0, k % 6, 0, k, k == 6, 0, k >= 5, k <= 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 6, 1, 0, 1, 0, 1, 0);
    step(1, 0, 0, 1, 0, 0, 0, 0, 6, 1, 0, 1, 0, 1, 0);
    for (int k = 1; k <= 6; k++)
      step(0, 1, 0, 0, 0, 1, 0, k % 6, 6 - k, 0, k == 6, (6 - k) >= 5, (6 - k) <= 1, 1, 0);
    step(1, 1, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1, 1, 1);
    step(1, 0, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1, 0, 3, 0, 3, 0, 0, 0, 0, 1, 1);
    step(1, 1, 0, 0, 1, 1, 4, 1, 3, 0, 0, 0, 0, 1, 1);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
    step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    for (int k = 1; k <= 6; k++)
      step(1, 0, 0, 0, 1, 0, k % 6, 0, k, k == 6, 0, k >= 5, k <= 1, 0, 0);
    drive(1, 1, 0, 0);
    push(2'b10, 1'b1, 1, 1, 1, 1, 6, 1, 0, 1, 0, 0, 0);
    push(2'b01, 1'b1, 0, 1, 0, 1, 5, 0, 0, 1, 0, 1, 0);
    drive(0, 0, 0, 0);
    @(negedge clk_in);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
